// File: rtl/object_dispatcher_pkg.sv
// Shared types for the object dispatcher: the object record, dispatcher states and helpers.
// The degenerate() helper is the single definition of the culling rule.
package object_dispatcher_pkg;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } vertex_t;

  typedef struct packed {
    vertex_t    a;
    vertex_t    b;
    vertex_t    c;
    logic [7:0] color;
  } object_t;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    FETCH,
    ARB,
    OFFER,
    DRAIN,
    DONE
  } dispatch_state_t;

  // Two coincident vertices means the triangle has zero area.
  function automatic logic degenerate(input object_t obj);
    return (obj.a == obj.b) || (obj.b == obj.c) || (obj.a == obj.c);
  endfunction

  function automatic int ptrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/object_dispatcher_if.sv
// Buffer-read and lane-handshake bundle between the object buffer, the dispatcher and the lanes.
// master = dispatcher side, slave = buffer/lane side.
interface object_dispatcher_if #(
  parameter int LANES = 4
);
  import object_dispatcher_pkg::*;

  object_t          buf_data;
  logic             buf_read_end;
  logic             buf_read;
  object_t          lane_obj;
  logic [LANES-1:0] lane_valid;
  logic [LANES-1:0] lane_ready;
  logic [LANES-1:0] lane_busy;

  modport master (
    input  buf_data, buf_read_end, lane_ready, lane_busy,
    output buf_read, lane_obj, lane_valid
  );

  modport slave (
    output buf_data, buf_read_end, lane_ready, lane_busy,
    input  buf_read, lane_obj, lane_valid
  );

endinterface

// File: rtl/object_dispatcher_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i, one-hot.
module rr_arbiter
  import object_dispatcher_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            req_i,
  input  logic [ptrWidth(N)-1:0]  ptr_i,
  output logic [N-1:0]            grant_o,
  output logic                    any_grant_o
);

  localparam int PTR_W = ptrWidth(N);

  logic [PTR_W-1:0] idx;

  // Walk the ring starting at the pointer; the first hit wins.
  always_comb begin
    grant_o     = '0;
    any_grant_o = 1'b0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr_i) + i) % N);
      if (!any_grant_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        any_grant_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/object_dispatcher.sv
// Per-frame scheduler: walks the object buffer and hands objects round-robin to rasterizer lanes.
// Optional build macro CULL_DEGENERATE_EN drops zero-area objects instead of dispatching them.
module object_dispatcher
  import object_dispatcher_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int COUNT_W = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  next_frame_i,
  object_dispatcher_if.master   bus,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  overrun_o,
  output logic [COUNT_W-1:0]    sent_count_o,
  output logic [COUNT_W-1:0]    cull_count_o
);

  localparam int PTR_W = ptrWidth(LANES);

  dispatch_state_t    state_q, state_d;
  logic [PTR_W-1:0]   rrPtr_q, rrPtr_d, grantIdx;
  logic [LANES-1:0]   grant_q, grant_d, arbGrant, laneValid;
  logic               arbAny, transfer, bufRead;
  object_t            laneObj_q, laneObj_d;
  logic               overrun_q, overrun_d;
  logic [COUNT_W-1:0] sentCount_q, sentCount_d;
`ifdef CULL_DEGENERATE_EN
  logic [COUNT_W-1:0] cullCount_q, cullCount_d;
`endif

  rr_arbiter #(.N(LANES)) uArbiter (
    .req_i       (bus.lane_ready),
    .ptr_i       (rrPtr_q),
    .grant_o     (arbGrant),
    .any_grant_o (arbAny)
  );

  assign laneValid = (state_q == OFFER) ? grant_q : '0;
  assign transfer  = (state_q == OFFER) && (|(grant_q & bus.lane_ready));

  always_comb begin
    grantIdx = '0;
    for (int i = 0; i < LANES; i++) begin
      if (grant_q[i]) grantIdx = PTR_W'(i);
    end
  end

  // A frame start always wins: it restarts the walk and abandons any pending offer.
  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    grant_d     = grant_q;
    laneObj_d   = laneObj_q;
    overrun_d   = overrun_q;
    sentCount_d = sentCount_q;
    bufRead     = 1'b0;
`ifdef CULL_DEGENERATE_EN
    cullCount_d = cullCount_q;
`endif
    if (next_frame_i) begin
      state_d     = SYNC;
      sentCount_d = '0;
`ifdef CULL_DEGENERATE_EN
      cullCount_d = '0;
`endif
      if (state_q != IDLE && state_q != DONE) overrun_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        SYNC: state_d = FETCH;
        FETCH: begin
          if (bus.buf_read_end) begin
            state_d = DRAIN;
          end else begin
            bufRead = 1'b1;
`ifdef CULL_DEGENERATE_EN
            if (degenerate(bus.buf_data)) begin
              if (!(&cullCount_q)) cullCount_d = cullCount_q + 1'b1;
            end else begin
              laneObj_d = bus.buf_data;
              state_d   = ARB;
            end
`else
            laneObj_d = bus.buf_data;
            state_d   = ARB;
`endif
          end
        end
        ARB: begin
          if (arbAny) begin
            grant_d = arbGrant;
            state_d = OFFER;
          end
        end
        OFFER: begin
          if (transfer) begin
            if (!(&sentCount_q)) sentCount_d = sentCount_q + 1'b1;
            rrPtr_d = (int'(grantIdx) == LANES - 1) ? '0 : grantIdx + 1'b1;
            state_d = FETCH;
          end
        end
        DRAIN: begin
          if (!(|bus.lane_busy) && !(|laneValid)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      grant_q     <= '0;
      laneObj_q   <= '0;
      overrun_q   <= 1'b0;
      sentCount_q <= '0;
`ifdef CULL_DEGENERATE_EN
      cullCount_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      grant_q     <= grant_d;
      laneObj_q   <= laneObj_d;
      overrun_q   <= overrun_d;
      sentCount_q <= sentCount_d;
`ifdef CULL_DEGENERATE_EN
      cullCount_q <= cullCount_d;
`endif
    end
  end

  assign bus.buf_read   = bufRead;
  assign bus.lane_obj   = laneObj_q;
  assign bus.lane_valid = laneValid;
  assign busy_o         = (state_q != IDLE);
  assign frame_done_o   = (state_q == DONE);
  assign overrun_o      = overrun_q;
  assign sent_count_o   = sentCount_q;
`ifdef CULL_DEGENERATE_EN
  assign cull_count_o   = cullCount_q;
`else
  assign cull_count_o   = '0;
`endif

endmodule

// File: tb/tb_object_dispatcher.sv
// Self-checking bench for object_dispatcher: buffer model, lane driver, transfer monitor and
// a round-robin reference model working from the dispatch rules (first ready lane from pointer).
module tb_object_dispatcher;
  import object_dispatcher_pkg::*;

  localparam int LANES   = 4;
  localparam int COUNT_W = 3;
  localparam logic [LANES-1:0] ALL_READY = '1;

  typedef struct {
    int      lane;
    object_t obj;
  } xfer_t;

  logic               clock     = 1'b0;
  logic               reset     = 1'b1;
  logic               nextFrame = 1'b0;
  logic               busy, frameDone, overrun;
  logic [COUNT_W-1:0] sentCount, cullCount;

  object_dispatcher_if #(.LANES(LANES)) bus();

  object_dispatcher #(.LANES(LANES), .COUNT_W(COUNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .next_frame_i (nextFrame),
    .bus          (bus.master),
    .busy_o       (busy),
    .frame_done_o (frameDone),
    .overrun_o    (overrun),
    .sent_count_o (sentCount),
    .cull_count_o (cullCount)
  );

  always #5 clock = ~clock;

  object_t mem [16];
  int      bufCount = 0;
  int      readPtr;

  always @(posedge clock or posedge reset) begin
    if (reset)               readPtr <= 0;
    else if (nextFrame)      readPtr <= 0;
    else if (bus.buf_read)   readPtr <= readPtr + 1;
  end

  assign bus.buf_data     = mem[readPtr[3:0]];
  assign bus.buf_read_end = (readPtr == bufCount);

  int    total = 0;
  int    bad   = 0;
  int    modelPtr = 0;
  xfer_t xferQ[$];
  xfer_t expQ[$];
  int    frameDoneCnt, bufReadCnt, onehotErr, stableErr;
  logic [LANES-1:0] prevValid;
  object_t          prevObj;
  bit               prevHold;

  // Observe the lane side between edges: transfers, one-hot and offer stability.
  always @(negedge clock) begin
    if (reset) begin
      prevHold = 1'b0;
    end else begin
      int lane;
      lane = -1;
      if ($countones(bus.lane_valid) > 1) onehotErr++;
      if (prevHold && (bus.lane_valid !== prevValid || bus.lane_obj !== prevObj)) stableErr++;
      if (frameDone === 1'b1) frameDoneCnt++;
      if (bus.buf_read === 1'b1) bufReadCnt++;
      for (int i = 0; i < LANES; i++) if (bus.lane_valid[i] && bus.lane_ready[i]) lane = i;
      if (!nextFrame && lane >= 0) xferQ.push_back('{lane: lane, obj: bus.lane_obj});
      prevHold  = (|bus.lane_valid) && (lane < 0) && !nextFrame;
      prevValid = bus.lane_valid;
      prevObj   = bus.lane_obj;
    end
  end

  function automatic bit isDegenerate(input object_t o);
    return (o.a.x == o.b.x && o.a.y == o.b.y) ||
           (o.b.x == o.c.x && o.b.y == o.c.y) ||
           (o.a.x == o.c.x && o.a.y == o.c.y);
  endfunction

  task automatic makeObj(input bit degen, output object_t o);
    o.a.x   = 8'($urandom);
    o.a.y   = 8'($urandom);
    o.b.x   = o.a.x + 8'($urandom_range(1, 200));
    o.b.y   = 8'($urandom);
    o.c.x   = o.a.x;
    o.c.y   = o.a.y + 8'($urandom_range(1, 200));
    o.color = 8'($urandom);
    if (degen) o.b = o.a;
  endtask

  task automatic fillBuffer(input int n);
    object_t o;
    for (int i = 0; i < n; i++) begin
      makeObj(1'b0, o);
      mem[i] = o;
    end
    bufCount = n;
  endtask

  // Reference round-robin: first ready lane at or after the pointer, pointer moves past it.
  task automatic pickLane(input logic [LANES-1:0] mask, output int lane);
    lane = -1;
    for (int k = 0; k < LANES; k++) begin
      int l;
      l = (modelPtr + k) % LANES;
      if (lane < 0 && mask[l]) lane = l;
    end
    if (lane >= 0) modelPtr = (lane + 1) % LANES;
  endtask

  task automatic appendExpected(input int n, input logic [LANES-1:0] mask,
                                output int sentExp, output int cullExp);
    sentExp = 0;
    cullExp = 0;
    for (int i = 0; i < n; i++) begin
      bit culled;
`ifdef CULL_DEGENERATE_EN
      culled = isDegenerate(mem[i]);
`else
      culled = 1'b0;
`endif
      if (culled) begin
        cullExp++;
      end else begin
        int l;
        pickLane(mask, l);
        expQ.push_back('{lane: l, obj: mem[i]});
        sentExp++;
      end
    end
  endtask

  task automatic clearMonitor();
    xferQ.delete();
    expQ.delete();
    frameDoneCnt = 0;
    bufReadCnt   = 0;
    onehotErr    = 0;
    stableErr    = 0;
  endtask

  task automatic pulseNextFrame();
    @(posedge clock); #1 nextFrame = 1'b1;
    @(posedge clock); #1 nextFrame = 1'b0;
  endtask

  task automatic waitFrameDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      @(negedge clock);
      if (frameDone === 1'b1) ok = 1'b1;
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    total += 8;
    if (busy !== 1'b0)           begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
    if (frameDone !== 1'b0)      begin bad++; $display("[TB] FAIL reset_frame_done got=%b exp=0", frameDone); end
    if (overrun !== 1'b0)        begin bad++; $display("[TB] FAIL reset_overrun got=%b exp=0", overrun); end
    if (bus.lane_valid !== '0)   begin bad++; $display("[TB] FAIL reset_lane_valid got=%b exp=0", bus.lane_valid); end
    if (bus.lane_obj !== '0)     begin bad++; $display("[TB] FAIL reset_lane_obj got=%h exp=0", bus.lane_obj); end
    if (bus.buf_read !== 1'b0)   begin bad++; $display("[TB] FAIL reset_buf_read got=%b exp=0", bus.buf_read); end
    if (sentCount !== '0)        begin bad++; $display("[TB] FAIL reset_sent got=%0d exp=0", sentCount); end
    if (cullCount !== '0)        begin bad++; $display("[TB] FAIL reset_cull got=%0d exp=0", cullCount); end
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    bit ok; int sentExp, cullExp;
    clearMonitor();
    fillBuffer(3);
    bus.lane_ready = ALL_READY;
    appendExpected(3, ALL_READY, sentExp, cullExp);
    pulseNextFrame();
    waitFrameDone(60, ok);
    @(posedge clock); #1;
    total += 4;
    if (!ok) begin bad++; $display("[TB] FAIL basic_done got=timeout exp=frame_done"); end
    if (xferQ.size() != 3) begin bad++; $display("[TB] FAIL basic_count got=%0d exp=3", xferQ.size()); end
    if (sentCount !== COUNT_W'(3)) begin bad++; $display("[TB] FAIL basic_sent got=%0d exp=3", sentCount); end
    if (frameDoneCnt != 1) begin bad++; $display("[TB] FAIL basic_done_pulses got=%0d exp=1", frameDoneCnt); end
    for (int i = 0; i < 3 && i < xferQ.size(); i++) begin
      total++;
      if (xferQ[i].lane != i || xferQ[i].obj !== mem[i] || expQ[i].lane != i) begin
        bad++;
        $display("[TB] FAIL basic_xfer[%0d] got lane=%0d obj=%h exp lane=%0d obj=%h",
                 i, xferQ[i].lane, xferQ[i].obj, i, mem[i]);
      end
    end
  endtask

  task automatic test_empty();
    int doneCycle;
    clearMonitor();
    bufCount = 0;
    doneCycle = -1;
    @(posedge clock); #1 nextFrame = 1'b1;
    @(posedge clock); #1 nextFrame = 1'b0;
    for (int c = 1; c <= 10 && doneCycle < 0; c++) begin
      @(negedge clock);
      if (frameDone === 1'b1) doneCycle = c;
    end
    @(posedge clock); #1;
    total += 3;
    if (doneCycle != 4) begin bad++; $display("[TB] FAIL empty_latency got=%0d exp=4", doneCycle); end
    if (sentCount !== '0) begin bad++; $display("[TB] FAIL empty_sent got=%0d exp=0", sentCount); end
    if (bufReadCnt != 0) begin bad++; $display("[TB] FAIL empty_buf_read got=%0d exp=0", bufReadCnt); end
  endtask

  task automatic test_single_lane();
    int sentExp, cullExp, c;
    clearMonitor();
    fillBuffer(2);
    bus.lane_ready = '0;
    appendExpected(2, 4'b0100, sentExp, cullExp);
    pulseNextFrame();
    for (c = 0; c < 300 && frameDoneCnt == 0; c++) begin
      bus.lane_ready = (c < 5) ? 4'b0100 : {1'b0, 1'($urandom_range(0, 1)), 2'b00};
      @(posedge clock); #1;
    end
    bus.lane_ready = '0;
    @(posedge clock); #1;
    total += 5;
    if (frameDoneCnt != 1) begin bad++; $display("[TB] FAIL lane2_done got=%0d exp=1", frameDoneCnt); end
    if (xferQ.size() != expQ.size()) begin bad++; $display("[TB] FAIL lane2_count got=%0d exp=%0d", xferQ.size(), expQ.size()); end
    if (onehotErr != 0) begin bad++; $display("[TB] FAIL lane2_onehot got=%0d exp=0", onehotErr); end
    if (stableErr != 0) begin bad++; $display("[TB] FAIL lane2_stable got=%0d exp=0", stableErr); end
    if (sentCount !== COUNT_W'(sentExp)) begin bad++; $display("[TB] FAIL lane2_sent got=%0d exp=%0d", sentCount, sentExp); end
    for (int i = 0; i < expQ.size() && i < xferQ.size(); i++) begin
      total++;
      if (xferQ[i].lane != 2 || xferQ[i].obj !== expQ[i].obj) begin
        bad++;
        $display("[TB] FAIL lane2_xfer[%0d] got lane=%0d obj=%h exp lane=2 obj=%h",
                 i, xferQ[i].lane, xferQ[i].obj, expQ[i].obj);
      end
    end
  endtask

  task automatic test_busy_drain();
    bit ok; int sentExp, cullExp;
    clearMonitor();
    fillBuffer(2);
    bus.lane_ready = ALL_READY;
    bus.lane_busy  = 4'b0010;
    appendExpected(2, ALL_READY, sentExp, cullExp);
    pulseNextFrame();
    for (int c = 0; c < 60 && xferQ.size() < 2; c++) begin
      @(posedge clock); #1;
    end
    repeat (10) begin
      @(posedge clock); #1;
    end
    total++;
    if (frameDoneCnt != 0) begin bad++; $display("[TB] FAIL drain_early_done got=%0d exp=0", frameDoneCnt); end
    bus.lane_busy = '0;
    waitFrameDone(6, ok);
    total += 3;
    if (!ok) begin bad++; $display("[TB] FAIL drain_done got=timeout exp=frame_done"); end
    if (sentCount !== COUNT_W'(sentExp)) begin bad++; $display("[TB] FAIL drain_sent got=%0d exp=%0d", sentCount, sentExp); end
    if (xferQ.size() != expQ.size()) begin bad++; $display("[TB] FAIL drain_count got=%0d exp=%0d", xferQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < xferQ.size(); i++) begin
      total++;
      if (xferQ[i].lane != expQ[i].lane || xferQ[i].obj !== expQ[i].obj) begin
        bad++;
        $display("[TB] FAIL drain_xfer[%0d] got lane=%0d exp lane=%0d", i, xferQ[i].lane, expQ[i].lane);
      end
    end
  endtask

  task automatic test_cull();
    bit ok; int sentExp, cullExp; object_t o;
    clearMonitor();
    makeObj(1'b0, o); mem[0] = o;
    makeObj(1'b1, o); mem[1] = o;
    makeObj(1'b0, o); mem[2] = o;
    bufCount = 3;
    bus.lane_ready = ALL_READY;
    appendExpected(3, ALL_READY, sentExp, cullExp);
    pulseNextFrame();
    waitFrameDone(60, ok);
    total += 4;
    if (!ok) begin bad++; $display("[TB] FAIL cull_done got=timeout exp=frame_done"); end
`ifdef CULL_DEGENERATE_EN
    if (sentCount !== COUNT_W'(2)) begin bad++; $display("[TB] FAIL cull_sent got=%0d exp=2", sentCount); end
    if (cullCount !== COUNT_W'(1)) begin bad++; $display("[TB] FAIL cull_culled got=%0d exp=1", cullCount); end
`else
    if (sentCount !== COUNT_W'(3)) begin bad++; $display("[TB] FAIL cull_sent got=%0d exp=3", sentCount); end
    if (cullCount !== '0) begin bad++; $display("[TB] FAIL cull_culled got=%0d exp=0", cullCount); end
`endif
    if (bufReadCnt != 3) begin bad++; $display("[TB] FAIL cull_buf_read got=%0d exp=3", bufReadCnt); end
    for (int i = 0; i < expQ.size(); i++) begin
      total++;
      if (i >= xferQ.size() || xferQ[i].lane != expQ[i].lane || xferQ[i].obj !== expQ[i].obj) begin
        bad++;
        $display("[TB] FAIL cull_xfer[%0d] got count=%0d exp lane=%0d obj=%h", i, xferQ.size(), expQ[i].lane, expQ[i].obj);
      end
    end
  endtask

  task automatic test_saturate();
    bit ok; int sentExp, cullExp;
    clearMonitor();
    fillBuffer(9);
    bus.lane_ready = ALL_READY;
    appendExpected(9, ALL_READY, sentExp, cullExp);
    pulseNextFrame();
    waitFrameDone(120, ok);
    total += 3;
    if (!ok) begin bad++; $display("[TB] FAIL sat_done got=timeout exp=frame_done"); end
    if (xferQ.size() != 9) begin bad++; $display("[TB] FAIL sat_count got=%0d exp=9", xferQ.size()); end
    if (sentCount !== COUNT_W'(7)) begin bad++; $display("[TB] FAIL sat_sent got=%0d exp=7", sentCount); end
  endtask

  task automatic test_random();
    bit ok; int sentExp, cullExp, n; object_t o; logic [LANES-1:0] mask;
    for (int f = 0; f < 6; f++) begin
      clearMonitor();
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        makeObj($urandom_range(0, 3) == 0, o);
        mem[i] = o;
      end
      bufCount = n;
      mask = LANES'($urandom_range(1, 15));
      bus.lane_ready = mask;
      appendExpected(n, mask, sentExp, cullExp);
      pulseNextFrame();
      waitFrameDone(150, ok);
      total += 4;
      if (!ok) begin bad++; $display("[TB] FAIL rand%0d_done got=timeout exp=frame_done", f); end
      if (sentCount !== COUNT_W'(sentExp)) begin bad++; $display("[TB] FAIL rand%0d_sent got=%0d exp=%0d", f, sentCount, sentExp); end
      if (cullCount !== COUNT_W'(cullExp)) begin bad++; $display("[TB] FAIL rand%0d_cull got=%0d exp=%0d", f, cullCount, cullExp); end
      if (xferQ.size() != expQ.size()) begin bad++; $display("[TB] FAIL rand%0d_count got=%0d exp=%0d", f, xferQ.size(), expQ.size()); end
      for (int i = 0; i < expQ.size() && i < xferQ.size(); i++) begin
        total++;
        if (xferQ[i].lane != expQ[i].lane || xferQ[i].obj !== expQ[i].obj) begin
          bad++;
          $display("[TB] FAIL rand%0d_xfer[%0d] got lane=%0d obj=%h exp lane=%0d obj=%h",
                   f, i, xferQ[i].lane, xferQ[i].obj, expQ[i].lane, expQ[i].obj);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok, seen; int sentExp, cullExp;
    clearMonitor();
    fillBuffer(2);
    bus.lane_ready = ALL_READY;
    appendExpected(2, ALL_READY, sentExp, cullExp);
    appendExpected(2, ALL_READY, sentExp, cullExp);
    pulseNextFrame();
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(posedge clock); #1;
      if (frameDone === 1'b1) seen = 1'b1;
    end
    nextFrame = 1'b1;
    @(posedge clock); #1 nextFrame = 1'b0;
    total += 3;
    if (!seen) begin bad++; $display("[TB] FAIL b2b_first_done got=timeout exp=frame_done"); end
    if (overrun !== 1'b0) begin bad++; $display("[TB] FAIL b2b_overrun got=%b exp=0", overrun); end
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL b2b_restart_busy got=%b exp=1", busy); end
    waitFrameDone(60, ok);
    total += 3;
    if (frameDoneCnt != 2) begin bad++; $display("[TB] FAIL b2b_done_pulses got=%0d exp=2", frameDoneCnt); end
    if (sentCount !== COUNT_W'(sentExp)) begin bad++; $display("[TB] FAIL b2b_sent got=%0d exp=%0d", sentCount, sentExp); end
    if (xferQ.size() != 4) begin bad++; $display("[TB] FAIL b2b_count got=%0d exp=4", xferQ.size()); end
    for (int i = 0; i < expQ.size() && i < xferQ.size(); i++) begin
      total++;
      if (xferQ[i].lane != expQ[i].lane || xferQ[i].obj !== expQ[i].obj) begin
        bad++;
        $display("[TB] FAIL b2b_xfer[%0d] got lane=%0d exp lane=%0d", i, xferQ[i].lane, expQ[i].lane);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok; int sentExp, cullExp; logic [LANES-1:0] offerMask;
    clearMonitor();
    fillBuffer(3);
    bus.lane_ready = '0;
    offerMask = LANES'(1) << modelPtr;
    pulseNextFrame();
    repeat (3) begin
      @(posedge clock); #1;
    end
    bus.lane_ready = offerMask;
    @(posedge clock); #1 bus.lane_ready = '0;
    @(negedge clock);
    total++;
    if (bus.lane_valid !== offerMask) begin bad++; $display("[TB] FAIL ovr_offer got=%b exp=%b", bus.lane_valid, offerMask); end
    @(posedge clock); #1 nextFrame = 1'b1;
    @(posedge clock); #1 nextFrame = 1'b0;
    @(negedge clock);
    total += 3;
    if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag got=%b exp=1", overrun); end
    if (bus.lane_valid !== '0) begin bad++; $display("[TB] FAIL ovr_valid_drop got=%b exp=0", bus.lane_valid); end
    if (xferQ.size() != 0) begin bad++; $display("[TB] FAIL ovr_no_xfer got=%0d exp=0", xferQ.size()); end
    appendExpected(3, ALL_READY, sentExp, cullExp);
    bus.lane_ready = ALL_READY;
    waitFrameDone(60, ok);
    @(posedge clock); #1;
    total += 4;
    if (frameDoneCnt != 1) begin bad++; $display("[TB] FAIL ovr_done_pulses got=%0d exp=1", frameDoneCnt); end
    if (sentCount !== COUNT_W'(3)) begin bad++; $display("[TB] FAIL ovr_sent got=%0d exp=3", sentCount); end
    if (overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_sticky got=%b exp=1", overrun); end
    if (xferQ.size() != 3) begin bad++; $display("[TB] FAIL ovr_count got=%0d exp=3", xferQ.size()); end
    for (int i = 0; i < expQ.size() && i < xferQ.size(); i++) begin
      total++;
      if (xferQ[i].lane != expQ[i].lane || xferQ[i].obj !== mem[i]) begin
        bad++;
        $display("[TB] FAIL ovr_xfer[%0d] got lane=%0d obj=%h exp lane=%0d obj=%h",
                 i, xferQ[i].lane, xferQ[i].obj, expQ[i].lane, mem[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bus.lane_ready = '0;
    bus.lane_busy  = '0;
    clearMonitor();
    test_reset();
    test_basic();
    test_empty();
    test_single_lane();
    test_busy_drain();
    test_cull();
    test_saturate();
    test_random();
    test_back_to_back();
    test_overrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
